// File: rtl/butterfly_pkg.sv
// Shared ButterFly types. This slice adds the memory-arbiter FSM state and owner enums.
package butterfly_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } arb_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_D
    } arb_owner_e;

    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/butterfly_mem_arbiter.sv
// Shares one memory bus between the fetch and data ports, with data priority.
// Define BUTTERFLY_ARB_FAIR_EN to add a fetch anti-starvation counter.
//
// state   | meaning
// IDLE    | bus free, arbitrate every cycle
// BUSY_IF | fetch transfer on bus, waiting for bus_ready_i
// BUSY_D  | data transfer on bus, waiting for bus_ready_i
module butterfly_mem_arbiter
    import butterfly_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,

    output logic        bus_valid_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ready_i
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    arb_state_e state;
    arb_owner_e winner;
    logic       arb_cycle;
    logic       win_valid;
    logic       force_if;

`ifdef BUTTERFLY_ARB_FAIR_EN
    logic [ARB_CNT_W-1:0] starve_cnt;
`endif

    // Grants are gated by rst_n_i so they drop the moment reset is asserted.
    always_comb begin
        force_if  = 1'b0;
`ifdef BUTTERFLY_ARB_FAIR_EN
        force_if  = (starve_cnt >= ARB_CNT_W'(STARVE_LIMIT));
`endif
        arb_cycle = rst_n_i && ((state == IDLE) || bus_ready_i);
        win_valid = arb_cycle && (if_req_i || d_req_i);
        winner    = (d_req_i && !(if_req_i && force_if)) ? OWNER_D : OWNER_IF;
    end

    assign if_gnt_o = win_valid && (winner == OWNER_IF);
    assign d_gnt_o  = win_valid && (winner == OWNER_D);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;

            if (state == BUSY_IF && bus_ready_i) begin
                if_rvalid_o <= 1'b1;
                if_rdata_o  <= bus_rdata_i;
            end
            if (state == BUSY_D && bus_ready_i) begin
                d_rvalid_o  <= 1'b1;
                d_rdata_o   <= bus_we_o ? '0 : bus_rdata_i;
            end

            // Completion and the next capture can share a cycle, so bus
            // fields are overwritten here right after the response is taken.
            if (arb_cycle) begin
                bus_valid_o <= win_valid;
                if (win_valid && winner == OWNER_D) begin
                    state       <= BUSY_D;
                    bus_we_o    <= d_we_i;
                    bus_addr_o  <= d_addr_i;
                    bus_wdata_o <= d_we_i ? d_wdata_i : '0;
                    bus_wstrb_o <= d_we_i ? d_wstrb_i : '0;
                end else if (win_valid) begin
                    state       <= BUSY_IF;
                    bus_we_o    <= 1'b0;
                    bus_addr_o  <= if_addr_i;
                    bus_wdata_o <= '0;
                    bus_wstrb_o <= '0;
                end else begin
                    state       <= IDLE;
                    bus_we_o    <= 1'b0;
                    bus_addr_o  <= '0;
                    bus_wdata_o <= '0;
                    bus_wstrb_o <= '0;
                end
            end
        end
    end

`ifdef BUTTERFLY_ARB_FAIR_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (arb_cycle) begin
            if (if_gnt_o) begin
                starve_cnt <= '0;
            end else if (d_gnt_o && if_req_i && starve_cnt != '1) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
